gray_seq_decoder: RTL and testbench

Receive-side counterpart to the 3-bit Gray-code sequence generator. Samples a Gray-coded state stream and decodes each sample to binary. Classifies each transition as step up, step down, hold or illegal, and keeps a wrap-around position count. Sits downstream of the Gray generator/flip-flop chain and checks its output.

---
 rtl/gray_seq_decoder_if.sv | 33 +++
 rtl/gray_seq_decoder.sv | 121 ++++++++++++
 tb/tb_gray_seq_decoder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/gray_seq_decoder_if.sv
// gray_seq_decoder_if
//   Bundles the sample stream and the decoder results.
//   master: drives in_valid/gray_in/clr_err, observes results (testbench/upstream)
//   slave : the decoder itself
//   in_valid, gray_in, clr_err        : sample strobe, Gray sample, error-counter clear
//   bin_out, step_up, step_dn, err    : decoded value and one-cycle classification pulses
//   locked, pos, err_cnt              : lock flag, modulo position, saturating error count
interface gray_seq_decoder_if #(
  parameter int WIDTH  = 3,
  parameter int POS_W  = 8,
  parameter int ERRC_W = 4
);
  logic              in_valid;
  logic [WIDTH-1:0]  gray_in;
  logic              clr_err;
  logic [WIDTH-1:0]  bin_out;
  logic              step_up;
  logic              step_dn;
  logic              err;
  logic              locked;
  logic [POS_W-1:0]  pos;
  logic [ERRC_W-1:0] err_cnt;

  modport master (
    output in_valid, gray_in, clr_err,
    input  bin_out, step_up, step_dn, err, locked, pos, err_cnt
  );

  modport slave (
    input  in_valid, gray_in, clr_err,
    output bin_out, step_up, step_dn, err, locked, pos, err_cnt
  );
endinterface

// File: rtl/gray_seq_decoder.sv
// gray_seq_decoder
//   Samples a Gray-coded state stream, decodes it to binary, classifies every
//   transition as step up / step down / hold / illegal and tracks a modulo
//   position plus a saturating error count. All outputs are registered
//   (one cycle from the in_valid sample).
//   clk   : system clock, rising edge
//   reset : synchronous, active-high, overrides everything
//   bus   : slave side of gray_seq_decoder_if (sample in, results out)
module gray_seq_decoder #(
  parameter int WIDTH  = 3,
  parameter int POS_W  = 8,
  parameter int ERRC_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  gray_seq_decoder_if.slave bus
);

  localparam logic [1:0] UNLOCKED = 2'd0;
  localparam logic [1:0] LOCKED   = 2'd1;
  localparam logic [1:0] FAULT    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;     // also serves as prev_bin
  logic              up_q, up_d;
  logic              dn_q, dn_d;
  logic              err_q, err_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [ERRC_W-1:0] errc_q, errc_d;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [WIDTH-1:0] new_bin, prev_gray, diff, bin_inc, bin_dec;
  logic             one_bit;

  // Previous Gray sample is re-encoded from the stored binary value rather
  // than kept in a second register; the two are always consistent.
  assign prev_gray = bin_q ^ (bin_q >> 1);
  assign new_bin   = gray2bin(bus.gray_in);
  assign diff      = bus.gray_in ^ prev_gray;
  // Hamming distance of exactly one: nonzero and a power of two.
  assign one_bit   = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
  assign bin_inc   = bin_q + WIDTH'(1);
  assign bin_dec   = bin_q - WIDTH'(1);

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    err_d   = 1'b0;
    pos_d   = pos_q;
    if (bus.in_valid) begin
      case (state_q)
        LOCKED: begin
          if (diff == '0) begin
            // hold: nothing changes
          end else if (one_bit && new_bin == bin_inc) begin
            up_d  = 1'b1;
            bin_d = new_bin;
            pos_d = pos_q + POS_W'(1);
          end else if (one_bit && new_bin == bin_dec) begin
            dn_d  = 1'b1;
            bin_d = new_bin;
            pos_d = pos_q - POS_W'(1);
          end else begin
            // d>=2, or a single-bit flip that lands on a non-adjacent code
            err_d   = 1'b1;
            bin_d   = new_bin;
            state_d = FAULT;
          end
        end
        default: begin
          // UNLOCKED and FAULT both (re)seed on the next sample, no pulses
          bin_d   = new_bin;
          state_d = LOCKED;
        end
      endcase
    end
  end

  // Clear applies first so a same-cycle error leaves the count at one.
  always_comb begin
    errc_d = bus.clr_err ? '0 : errc_q;
    if (err_d && errc_d != '1) errc_d = errc_d + ERRC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= UNLOCKED;
      bin_q   <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      err_q   <= 1'b0;
      pos_q   <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      err_q   <= err_d;
      pos_q   <= pos_d;
      errc_q  <= errc_d;
    end
  end

  assign bus.bin_out = bin_q;
  assign bus.step_up = up_q;
  assign bus.step_dn = dn_q;
  assign bus.err     = err_q;
  assign bus.locked  = (state_q == LOCKED);
  assign bus.pos     = pos_q;
  assign bus.err_cnt = errc_q;

endmodule

// File: tb/tb_gray_seq_decoder.sv
module tb_gray_seq_decoder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gray_seq_decoder_if #(.WIDTH(3), .POS_W(8), .ERRC_W(4)) bus();

  gray_seq_decoder #(.WIDTH(3), .POS_W(8), .ERRC_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [2:0] bin;
    logic       up;
    logic       dn;
    logic       err;
    logic       lk;
    logic [7:0] pos;
    logic [3:0] ec;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Apply one cycle of stimulus and queue the result expected after the edge.
  task automatic t(input logic r, input logic v, input logic [2:0] g, input logic c,
                   input logic [2:0] b, input logic u, input logic d, input logic e,
                   input logic l, input logic [7:0] p, input logic [3:0] ec);
    exp_t x;
    @(negedge clk);
    reset        = r;
    bus.in_valid = v;
    bus.gray_in  = g;
    bus.clr_err  = c;
    x.bin = b; x.up = u; x.dn = d; x.err = e; x.lk = l; x.pos = p; x.ec = ec;
    q.push_back(x);
  endtask

  // Monitor: compares every queued expectation one step after the edge.
  always @(posedge clk) begin
    exp_t e, a;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      a.bin = bus.bin_out; a.up = bus.step_up; a.dn = bus.step_dn; a.err = bus.err;
      a.lk = bus.locked; a.pos = bus.pos; a.ec = bus.err_cnt;
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL chk%0d got bin=%0d up=%0b dn=%0b err=%0b lk=%0b pos=%0d ec=%0d required bin=%0d up=%0b dn=%0b err=%0b lk=%0b pos=%0d ec=%0d",
                    n_chk, a.bin, a.up, a.dn, a.err, a.lk, a.pos, a.ec,
                    e.bin, e.up, e.dn, e.err, e.lk, e.pos, e.ec);
    end
  end

  initial begin
    reset = 1'b1; bus.in_valid = 1'b0; bus.gray_in = 3'b000; bus.clr_err = 1'b0;
    // reset, then idle
    t(1,0,3'b000,0, 0,0,0,0,0, 0,0);
    for (int i = 0; i < 5; i++) t(0,0,3'b000,0, 0,0,0,0,0, 0,0);
    // first sample locks only
    t(0,1,3'b000,0, 0,0,0,0,1, 0,0);
    // full up sequence with 7->0 wrap
    t(0,1,3'b001,0, 1,1,0,0,1, 1,0);
    t(0,1,3'b011,0, 2,1,0,0,1, 2,0);
    t(0,1,3'b010,0, 3,1,0,0,1, 3,0);
    t(0,1,3'b110,0, 4,1,0,0,1, 4,0);
    t(0,1,3'b111,0, 5,1,0,0,1, 5,0);
    t(0,1,3'b101,0, 6,1,0,0,1, 6,0);
    t(0,1,3'b100,0, 7,1,0,0,1, 7,0);
    t(0,1,3'b000,0, 0,1,0,0,1, 8,0);
    // hold
    t(0,1,3'b000,0, 0,0,0,0,1, 8,0);
    // in_valid low: frozen
    for (int i = 0; i < 3; i++) t(0,0,3'b111,0, 0,0,0,0,1, 8,0);
    // up, then d=2 error, then resync
    t(0,1,3'b001,0, 1,1,0,0,1, 9,0);
    t(0,1,3'b111,0, 5,0,0,1,0, 9,1);
    t(0,1,3'b110,0, 4,0,0,0,1, 9,1);
    // d=3 error, resync at 001, then 001->101 (d=1, bin 1->6) error
    t(0,1,3'b001,0, 1,0,0,1,0, 9,2);
    t(0,1,3'b001,0, 1,0,0,0,1, 9,2);
    t(0,1,3'b101,0, 6,0,0,1,0, 9,3);
    // 20 more errors: count saturates at 15
    for (int i = 1; i <= 20; i++) begin
      t(0,1,3'b000,0, 0,0,0,0,1, 9, 4'((2+i) > 15 ? 15 : (2+i)));
      t(0,1,3'b111,0, 5,0,0,1,0, 9, 4'((3+i) > 15 ? 15 : (3+i)));
    end
    // clr_err together with a new error -> 1; clr alone -> 0
    t(0,1,3'b000,0, 0,0,0,0,1, 9,15);
    t(0,1,3'b111,1, 5,0,0,1,0, 9,1);
    t(0,0,3'b111,1, 5,0,0,0,0, 9,0);
    // reset mid-operation at pos=5 with in_valid high
    t(1,0,3'b000,0, 0,0,0,0,0, 0,0);
    t(0,1,3'b000,0, 0,0,0,0,1, 0,0);
    t(0,1,3'b001,0, 1,1,0,0,1, 1,0);
    t(0,1,3'b011,0, 2,1,0,0,1, 2,0);
    t(0,1,3'b010,0, 3,1,0,0,1, 3,0);
    t(0,1,3'b110,0, 4,1,0,0,1, 4,0);
    t(0,1,3'b111,0, 5,1,0,0,1, 5,0);
    t(1,1,3'b101,1, 0,0,0,0,0, 0,0);
    t(0,1,3'b101,0, 6,0,0,0,1, 0,0);
    // down wrap 0->7 and pos 0->255->254, then back up across 255->0
    t(1,0,3'b000,0, 0,0,0,0,0, 0,0);
    t(0,1,3'b000,0, 0,0,0,0,1, 0,0);
    t(0,1,3'b100,0, 7,0,1,0,1, 255,0);
    t(0,1,3'b101,0, 6,0,1,0,1, 254,0);
    t(0,1,3'b100,0, 7,1,0,0,1, 255,0);
    t(0,1,3'b000,0, 0,1,0,0,1, 0,0);
    // drain
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain got %0d pending required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
